// File: rtl/fifo_ctrl_32x8.sv
// Single-clock FIFO controller driving a 32x8 single-port RAM, with a show-ahead output register.
// Define FIFO_ALMOST_FLAGS_EN to add the Almost_Full / Almost_Empty outputs.
module fifo_ctrl_32x8
`ifdef FIFO_ALMOST_FLAGS_EN
#(
    parameter int ALMOST_FULL_TH  = 28,
    parameter int ALMOST_EMPTY_TH = 4
)
`endif
(
    input  logic       Clock,
    input  logic       Reset_n,
    input  logic       Push_Valid,
    input  logic [7:0] Push_Data,
    output logic       Push_Ready,
    output logic       Pop_Valid,
    output logic [7:0] Pop_Data,
    input  logic       Pop_Ready,
    output logic [4:0] Ram_Address,
    output logic [7:0] Ram_Data,
    output logic       Ram_Write_Enable,
    output logic       Ram_Chip_Select,
    input  logic [7:0] Ram_Output,
    output logic       Full,
    output logic       Empty,
`ifdef FIFO_ALMOST_FLAGS_EN
    output logic       Almost_Full,
    output logic       Almost_Empty,
`endif
    output logic [5:0] Count
);

    typedef enum logic {
        GRANT_WRITE = 1'b0,
        GRANT_READ  = 1'b1
    } grant_e;

    localparam logic [5:0] DEPTH = 6'd32;

    logic [4:0] wr_ptr;
    logic [4:0] rd_ptr;
    logic       rd_pending;
    grant_e     last_grant;

    logic wr_req;
    logic rd_req;
    logic wr_grant;
    logic rd_grant;

    // A read may only be issued when the output slot is free by the capture edge,
    // so the show-ahead register can never be overwritten.
    assign wr_req = Push_Valid && (Count < DEPTH);
    assign rd_req = (Count != 6'd0) && !rd_pending && (!Pop_Valid || Pop_Ready);

    // Round-robin between the two requesters on the single RAM port.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        wr_grant = 1'b0;
        rd_grant = 1'b0;
        if (wr_req && rd_req) begin
            wr_grant = (last_grant == GRANT_READ);
            rd_grant = (last_grant == GRANT_WRITE);
        end else begin
            wr_grant = wr_req;
            rd_grant = rd_req;
        end
    end

    assign Push_Ready = wr_grant;
    assign Full       = (Count == DEPTH);
    assign Empty      = (Count == 6'd0) && !Pop_Valid && !rd_pending;

`ifdef FIFO_ALMOST_FLAGS_EN
    localparam logic [5:0] AF_TH = 6'(ALMOST_FULL_TH);
    localparam logic [5:0] AE_TH = 6'(ALMOST_EMPTY_TH);

    assign Almost_Full  = (Count >= AF_TH);
    assign Almost_Empty = (Count <= AE_TH);
`endif

    // RAM drive: address/data hold when idle, strobes drop.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            Ram_Address      <= 5'd0;
            Ram_Data         <= 8'd0;
            Ram_Write_Enable <= 1'b0;
            Ram_Chip_Select  <= 1'b0;
        end else begin
            Ram_Write_Enable <= 1'b0;
            Ram_Chip_Select  <= 1'b0;
            if (wr_grant) begin
                Ram_Address      <= wr_ptr;
                Ram_Data         <= Push_Data;
                Ram_Write_Enable <= 1'b1;
                Ram_Chip_Select  <= 1'b1;
            end else if (rd_grant) begin
                Ram_Address     <= rd_ptr;
                Ram_Chip_Select <= 1'b1;
            end
        end
    end

    // Pointers, occupancy and arbitration history.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            wr_ptr     <= 5'd0;
            rd_ptr     <= 5'd0;
            Count      <= 6'd0;
            last_grant <= GRANT_WRITE;
        end else begin
            if (wr_grant) begin
                wr_ptr     <= wr_ptr + 5'd1;
                Count      <= Count + 6'd1;
                last_grant <= GRANT_WRITE;
            end else if (rd_grant) begin
                rd_ptr     <= rd_ptr + 5'd1;
                Count      <= Count - 6'd1;
                last_grant <= GRANT_READ;
            end
        end
    end

    // Show-ahead output slot: RAM data is valid the cycle after a read grant.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            rd_pending <= 1'b0;
            Pop_Valid  <= 1'b0;
            Pop_Data   <= 8'd0;
        end else begin
            rd_pending <= rd_grant;
            if (rd_pending) begin
                Pop_Valid <= 1'b1;
                Pop_Data  <= Ram_Output;
            end else if (Pop_Valid && Pop_Ready) begin
                Pop_Valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fifo_ctrl_32x8.sv
// Directed bench for fifo_ctrl_32x8: vector table plus fill/drain, contention and reset sequences.
// A behavioural RAM and a data scoreboard sit alongside the DUT.
module tb_fifo_ctrl_32x8;

    logic       Clock = 1'b0;
    logic       Reset_n = 1'b0;
    logic       Push_Valid = 1'b0;
    logic [7:0] Push_Data = 8'd0;
    logic       Push_Ready;
    logic       Pop_Valid;
    logic [7:0] Pop_Data;
    logic       Pop_Ready = 1'b0;
    logic [4:0] Ram_Address;
    logic [7:0] Ram_Data;
    logic       Ram_Write_Enable;
    logic       Ram_Chip_Select;
    logic [7:0] Ram_Output;
    logic       Full;
    logic       Empty;
    logic [5:0] Count;
`ifdef FIFO_ALMOST_FLAGS_EN
    logic       Almost_Full;
    logic       Almost_Empty;
`endif

    int checks = 0;
    int failures = 0;
    int pops = 0;
    logic [7:0] sb[$];
    logic [7:0] mem[32];

    fifo_ctrl_32x8 dut (
        .Clock            (Clock),
        .Reset_n          (Reset_n),
        .Push_Valid       (Push_Valid),
        .Push_Data        (Push_Data),
        .Push_Ready       (Push_Ready),
        .Pop_Valid        (Pop_Valid),
        .Pop_Data         (Pop_Data),
        .Pop_Ready        (Pop_Ready),
        .Ram_Address      (Ram_Address),
        .Ram_Data         (Ram_Data),
        .Ram_Write_Enable (Ram_Write_Enable),
        .Ram_Chip_Select  (Ram_Chip_Select),
        .Ram_Output       (Ram_Output),
        .Full             (Full),
        .Empty            (Empty),
`ifdef FIFO_ALMOST_FLAGS_EN
        .Almost_Full      (Almost_Full),
        .Almost_Empty     (Almost_Empty),
`endif
        .Count            (Count)
    );

    always #5 Clock = ~Clock;

    // Behavioural RAM: asynchronous read, write committed at the edge ending the write cycle.
    initial for (int i = 0; i < 32; i++) mem[i] = 8'h00;
    always @(posedge Clock) if (Ram_Chip_Select && Ram_Write_Enable) mem[Ram_Address] <= Ram_Data;
    assign Ram_Output = mem[Ram_Address];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    // Handshake monitor: pops are matched against earlier pushes before this cycle's push is queued.
    always @(negedge Clock) begin
        if (Reset_n) begin
            if (Pop_Valid && Pop_Ready) begin
                pops++;
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL pop_unexpected: actual=0x%0h required=none", Pop_Data);
                end else begin
                    check("pop_order", 32'(Pop_Data), 32'(sb.pop_front()));
                end
            end
            if (Push_Valid && Push_Ready) sb.push_back(Push_Data);
        end
    end

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic do_reset();
        Reset_n    = 1'b0;
        Push_Valid = 1'b0;
        Pop_Ready  = 1'b0;
        sb.delete();
        repeat (2) @(posedge Clock);
        @(negedge Clock);
        Reset_n = 1'b1;
        tick();
    endtask

    task automatic push(input logic [7:0] d);
        bit done = 0;
        Push_Valid = 1'b1;
        Push_Data  = d;
        for (int n = 0; n < 8 && !done; n++) begin
            @(negedge Clock);
            if (Push_Ready) done = 1;
            tick();
        end
        check($sformatf("push_accepted_%0h", d), 32'(done), 32'd1);
        Push_Valid = 1'b0;
    endtask

    task automatic drain(input string name);
        int n = 0;
        Pop_Ready = 1'b1;
        while (!Empty && n < 200) begin
            tick();
            n++;
        end
        check({name, "_empty"}, 32'(Empty), 32'd1);
        check({name, "_count"}, 32'(Count), 32'd0);
        check({name, "_sb_left"}, 32'(sb.size()), 32'd0);
    endtask

    typedef struct {
        logic       pv;
        logic [7:0] pd;
        logic       pr;
        logic       e_push_ready;
        logic       e_we;
        logic       e_cs;
        logic [4:0] e_addr;
        logic [7:0] e_ram_data;
        logic [5:0] e_count;
        logic       e_pop_valid;
        logic [7:0] e_pop_data;
        logic       e_empty;
        logic       e_full;
    } vec_t;

    vec_t vecs[9];

    initial begin
        logic prev_we;
        logic [5:0] prev_count;
        int n;

        #1;
        check("rst_empty", 32'(Empty), 32'd1);
        check("rst_popv", 32'(Pop_Valid), 32'd0);
        check("rst_cs", 32'(Ram_Chip_Select), 32'd0);
        check("rst_count", 32'(Count), 32'd0);
`ifdef FIFO_ALMOST_FLAGS_EN
        check("rst_almost_full", 32'(Almost_Full), 32'd0);
        check("rst_almost_empty", 32'(Almost_Empty), 32'd1);
`endif
        do_reset();

        // Five idle cycles, then one push of 0xA5 with the consumer always ready.
        for (int i = 0; i < 5; i++)
            vecs[i] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 8'h00, 6'd0, 1'b0, 8'h00, 1'b1, 1'b0};
        vecs[5] = '{1'b1, 8'hA5, 1'b1, 1'b1, 1'b1, 1'b1, 5'd0, 8'hA5, 6'd1, 1'b0, 8'h00, 1'b0, 1'b0};
        vecs[6] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 5'd0, 8'hA5, 6'd0, 1'b0, 8'h00, 1'b0, 1'b0};
        vecs[7] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 8'hA5, 6'd0, 1'b1, 8'hA5, 1'b0, 1'b0};
        vecs[8] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 8'hA5, 6'd0, 1'b0, 8'hA5, 1'b1, 1'b0};

        foreach (vecs[i]) begin
            Push_Valid = vecs[i].pv;
            Push_Data  = vecs[i].pd;
            Pop_Ready  = vecs[i].pr;
            @(negedge Clock);
            check($sformatf("v%0d_push_ready", i), 32'(Push_Ready), 32'(vecs[i].e_push_ready));
            tick();
            check($sformatf("v%0d_we", i), 32'(Ram_Write_Enable), 32'(vecs[i].e_we));
            check($sformatf("v%0d_cs", i), 32'(Ram_Chip_Select), 32'(vecs[i].e_cs));
            check($sformatf("v%0d_addr", i), 32'(Ram_Address), 32'(vecs[i].e_addr));
            check($sformatf("v%0d_ram_data", i), 32'(Ram_Data), 32'(vecs[i].e_ram_data));
            check($sformatf("v%0d_count", i), 32'(Count), 32'(vecs[i].e_count));
            check($sformatf("v%0d_popv", i), 32'(Pop_Valid), 32'(vecs[i].e_pop_valid));
            check($sformatf("v%0d_popd", i), 32'(Pop_Data), 32'(vecs[i].e_pop_data));
            check($sformatf("v%0d_empty", i), 32'(Empty), 32'(vecs[i].e_empty));
            check($sformatf("v%0d_full", i), 32'(Full), 32'(vecs[i].e_full));
        end
        Push_Valid = 1'b0;
        Pop_Ready  = 1'b0;

        // Fill: the first entry is prefetched into the output slot, so 33 entries fit.
        do_reset();
        for (int d = 0; d < 32; d++) push(8'(d));
        check("fill_count31", 32'(Count), 32'd31);
        check("fill_popv", 32'(Pop_Valid), 32'd1);
        check("fill_popd", 32'(Pop_Data), 32'h00);
        check("fill_not_full", 32'(Full), 32'd0);
        push(8'h20);
        check("fill_count32", 32'(Count), 32'd32);
        check("fill_full", 32'(Full), 32'd1);
        check("fill_wrap_addr", 32'(Ram_Address), 32'd0);
        check("fill_wrap_we", 32'(Ram_Write_Enable), 32'd1);

        Push_Valid = 1'b1;
        Push_Data  = 8'h55;
        for (int i = 0; i < 3; i++) begin
            @(negedge Clock);
            check("full_push_ready", 32'(Push_Ready), 32'd0);
            tick();
            check("full_count", 32'(Count), 32'd32);
            check("full_cs", 32'(Ram_Chip_Select), 32'd0);
        end
        Push_Valid = 1'b0;

        pops = 0;
        drain("drain_full");
        check("drain_pops", 32'(pops), 32'd33);

        // Simultaneous traffic from Count = 10: grants alternate every cycle.
        do_reset();
        for (int d = 0; d < 11; d++) push(8'(d));
        check("alt_start_count", 32'(Count), 32'd10);
        Push_Valid = 1'b1;
        Push_Data  = 8'd11;
        Pop_Ready  = 1'b1;
        prev_we    = 1'b0;
        prev_count = Count;
        for (int i = 0; i < 16; i++) begin
            logic hs;
            @(negedge Clock);
            hs = Push_Ready;
            tick();
            if (hs) Push_Data = Push_Data + 8'd1;
            check("alt_cs", 32'(Ram_Chip_Select), 32'd1);
            if (i > 0) check("alt_we", 32'(Ram_Write_Enable), 32'(!prev_we));
            check("alt_count_range", 32'(Count >= 6'd9 && Count <= 6'd11), 32'd1);
            check("alt_count_step", 32'(Count == prev_count + 6'd1 || Count == prev_count - 6'd1), 32'd1);
            prev_we    = Ram_Write_Enable;
            prev_count = Count;
        end
        Push_Valid = 1'b0;
        drain("alt_drain");

        // Reset asserted while a RAM read is in flight.
        do_reset();
        push(8'h11);
        push(8'h22);
        push(8'h33);
        Pop_Ready = 1'b1;
        n = 0;
        do begin
            tick();
            n++;
        end while (!(Ram_Chip_Select && !Ram_Write_Enable) && n < 6);
        check("mid_read_issued", 32'(Ram_Chip_Select && !Ram_Write_Enable), 32'd1);
        #1;
        Reset_n = 1'b0;
        sb.delete();
        #1;
        check("mid_rst_popv", 32'(Pop_Valid), 32'd0);
        check("mid_rst_count", 32'(Count), 32'd0);
        check("mid_rst_cs", 32'(Ram_Chip_Select), 32'd0);
        check("mid_rst_empty", 32'(Empty), 32'd1);
        @(negedge Clock);
        Reset_n = 1'b1;
        tick();
        check("post_rst_popv", 32'(Pop_Valid), 32'd0);
        push(8'h3C);
        check("post_rst_wr_addr", 32'(Ram_Address), 32'd0);
        check("post_rst_wr_we", 32'(Ram_Write_Enable), 32'd1);
        tick();
        check("post_rst_rd_addr", 32'(Ram_Address), 32'd0);
        check("post_rst_rd_cs", 32'(Ram_Chip_Select && !Ram_Write_Enable), 32'd1);
        tick();
        check("post_rst_popv", 32'(Pop_Valid), 32'd1);
        check("post_rst_popd", 32'(Pop_Data), 32'h3C);
        tick();
        check("post_rst_empty", 32'(Empty), 32'd1);
        Pop_Ready = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
